// File: rtl/ptw_module.sv
// rtl/ptw_module.sv - Sv32 two-level page-table walker with PTE-cache probe and refill
module ptw_module #(
    parameter int VADDR_WIDTH = 32,
    parameter int PADDR_WIDTH = 34,
    parameter int PTE_WIDTH   = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            i_csr_satp,
    input  logic                   i_ptw_flush,
    input  logic                   i_ptw_req_vld,
    output logic                   o_ptw_req_rdy,
    input  logic [VADDR_WIDTH-1:0] i_ptw_req_vaddr,
    input  logic                   i_ptw_req_store,
    output logic                   o_ptw_cache_rden,
    output logic [VADDR_WIDTH-1:0] o_ptw_cache_vaddr,
    input  logic                   i_ptw_cache_hit,
    input  logic [PTE_WIDTH+1:0]   i_ptw_cache_rdata,
    output logic                   o_ptw_cache_wren,
    output logic [1:0]             o_ptw_cache_level,
    output logic [PTE_WIDTH-1:0]   o_ptw_cache_pte,
    output logic                   o_ptw_mem_req_vld,
    input  logic                   i_ptw_mem_req_rdy,
    output logic [PADDR_WIDTH-1:0] o_ptw_mem_addr,
    input  logic                   i_ptw_mem_resp_vld,
    input  logic [PTE_WIDTH-1:0]   i_ptw_mem_resp_data,
    input  logic                   i_ptw_mem_resp_err,
    output logic                   o_ptw_resp_vld,
    input  logic                   i_ptw_resp_rdy,
    output logic [PTE_WIDTH-1:0]   o_ptw_resp_pte,
    output logic [1:0]             o_ptw_resp_level,
    output logic                   o_ptw_resp_pf,
    output logic                   o_ptw_resp_af
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_L1_REQ, S_L1_WAIT, S_L0_REQ, S_L0_WAIT, S_RESP, S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] vaddr_q;
    logic        store_q;
    logic [21:0] root_ppn_q;
    logic [21:0] l0_ppn_q;
    logic [31:0] resp_pte_q;
    logic [1:0]  resp_level_q;
    logic        resp_pf_q, resp_af_q, wren_q;

    logic        req_accept, load_l0, load_resp, nxt_wren, nxt_pf, nxt_af;
    logic [31:0] nxt_pte;
    logic [1:0]  nxt_level;

    logic        unused_satp_hi;
    assign unused_satp_hi = ^i_csr_satp[31:22];

    // Classification of the PTE returned by memory at the current walk level.
    logic [31:0] mem_pte;
    logic        at_level1, pte_bad, pte_leaf, pte_misaligned, pte_ad_fault, mem_pf, mem_ptr, hit_pf;
    assign mem_pte        = i_ptw_mem_resp_data;
    assign at_level1      = (state_q == S_L1_WAIT);
    assign pte_bad        = !mem_pte[0] || (!mem_pte[1] && mem_pte[2]);
    assign pte_leaf       = mem_pte[1] || mem_pte[3];
    assign pte_misaligned = at_level1 && (mem_pte[19:10] != 10'd0);
    assign pte_ad_fault   = !mem_pte[6] || (store_q && !mem_pte[7]);
    assign mem_pf         = pte_bad || (pte_leaf ? (pte_misaligned || pte_ad_fault) : !at_level1);
    assign mem_ptr        = !pte_bad && !pte_leaf && at_level1;
    assign hit_pf         = !i_ptw_cache_rdata[6] || (store_q && !i_ptw_cache_rdata[7]);

    always_comb begin
        state_d           = state_q;
        req_accept        = 1'b0;
        load_l0           = 1'b0;
        load_resp         = 1'b0;
        nxt_wren          = 1'b0;
        nxt_pf            = 1'b0;
        nxt_af            = 1'b0;
        nxt_pte           = mem_pte;
        nxt_level         = {1'b0, at_level1};
        o_ptw_req_rdy     = 1'b0;
        o_ptw_cache_rden  = 1'b0;
        o_ptw_mem_req_vld = 1'b0;
        o_ptw_mem_addr    = '0;
        o_ptw_resp_vld    = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_ptw_req_rdy = !i_ptw_flush;
                if (i_ptw_req_vld && !i_ptw_flush) begin
                    req_accept = 1'b1;
                    state_d    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                o_ptw_cache_rden = 1'b1;
                if (i_ptw_flush) begin
                    state_d = S_IDLE;
                end else if (i_ptw_cache_hit) begin
                    load_resp = 1'b1;
                    nxt_pte   = i_ptw_cache_rdata[31:0];
                    nxt_level = i_ptw_cache_rdata[33:32];
                    nxt_pf    = hit_pf;
                    state_d   = S_RESP;
                end else begin
                    state_d = S_L1_REQ;
                end
            end
            S_L1_REQ, S_L0_REQ: begin
                o_ptw_mem_req_vld = 1'b1;
                o_ptw_mem_addr    = (state_q == S_L1_REQ) ? {root_ppn_q, vaddr_q[31:22], 2'b00}
                                                          : {l0_ppn_q, vaddr_q[21:12], 2'b00};
                if (i_ptw_flush)
                    state_d = i_ptw_mem_req_rdy ? S_DRAIN : S_IDLE;
                else if (i_ptw_mem_req_rdy)
                    state_d = (state_q == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
            end
            S_L1_WAIT, S_L0_WAIT: begin
                // A response arriving with the flush is already consumed, so no drain is needed.
                if (i_ptw_flush) begin
                    state_d = i_ptw_mem_resp_vld ? S_IDLE : S_DRAIN;
                end else if (i_ptw_mem_resp_vld) begin
                    if (i_ptw_mem_resp_err) begin
                        load_resp = 1'b1;
                        nxt_af    = 1'b1;
                        state_d   = S_RESP;
                    end else if (mem_ptr) begin
                        load_l0 = 1'b1;
                        state_d = S_L0_REQ;
                    end else begin
                        load_resp = 1'b1;
                        nxt_pf    = mem_pf;
                        nxt_wren  = !mem_pf;
                        state_d   = S_RESP;
                    end
                end
            end
            S_RESP: begin
                o_ptw_resp_vld = !i_ptw_flush;
                if (i_ptw_flush || i_ptw_resp_rdy)
                    state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (i_ptw_mem_resp_vld)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            vaddr_q      <= '0;
            store_q      <= 1'b0;
            root_ppn_q   <= '0;
            l0_ppn_q     <= '0;
            resp_pte_q   <= '0;
            resp_level_q <= '0;
            resp_pf_q    <= 1'b0;
            resp_af_q    <= 1'b0;
            wren_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (req_accept) begin
                vaddr_q    <= i_ptw_req_vaddr;
                store_q    <= i_ptw_req_store;
                root_ppn_q <= i_csr_satp[21:0];
            end
            if (load_l0)
                l0_ppn_q <= mem_pte[31:10];
            if (load_resp) begin
                resp_pte_q   <= nxt_pte;
                resp_level_q <= nxt_level;
                resp_pf_q    <= nxt_pf;
                resp_af_q    <= nxt_af;
            end
            wren_q <= load_resp && nxt_wren;
        end
    end

    assign o_ptw_cache_vaddr = vaddr_q;
    assign o_ptw_cache_wren  = wren_q && !i_ptw_flush;
    assign o_ptw_cache_level = resp_level_q;
    assign o_ptw_cache_pte   = resp_pte_q;
    assign o_ptw_resp_pte    = resp_pte_q;
    assign o_ptw_resp_level  = resp_level_q;
    assign o_ptw_resp_pf     = resp_pf_q;
    assign o_ptw_resp_af     = resp_af_q;

endmodule

// File: tb/tb_ptw_module.sv
// tb/tb_ptw_module.sv - randomized scoreboard bench for the Sv32 page-table walker
module tb_ptw_module;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i_csr_satp = '0;
    logic        i_ptw_flush = 1'b0;
    logic        i_ptw_req_vld = 1'b0;
    logic        o_ptw_req_rdy;
    logic [31:0] i_ptw_req_vaddr = '0;
    logic        i_ptw_req_store = 1'b0;
    logic        o_ptw_cache_rden;
    logic [31:0] o_ptw_cache_vaddr;
    logic        i_ptw_cache_hit = 1'b0;
    logic [33:0] i_ptw_cache_rdata = '0;
    logic        o_ptw_cache_wren;
    logic [1:0]  o_ptw_cache_level;
    logic [31:0] o_ptw_cache_pte;
    logic        o_ptw_mem_req_vld;
    logic        i_ptw_mem_req_rdy = 1'b0;
    logic [33:0] o_ptw_mem_addr;
    logic        i_ptw_mem_resp_vld = 1'b0;
    logic [31:0] i_ptw_mem_resp_data = '0;
    logic        i_ptw_mem_resp_err = 1'b0;
    logic        o_ptw_resp_vld;
    logic        i_ptw_resp_rdy = 1'b0;
    logic [31:0] o_ptw_resp_pte;
    logic [1:0]  o_ptw_resp_level;
    logic        o_ptw_resp_pf;
    logic        o_ptw_resp_af;

    always #5 clk = ~clk;

    ptw_module dut (
        .clk(clk), .rst_n(rst_n), .i_csr_satp(i_csr_satp), .i_ptw_flush(i_ptw_flush),
        .i_ptw_req_vld(i_ptw_req_vld), .o_ptw_req_rdy(o_ptw_req_rdy),
        .i_ptw_req_vaddr(i_ptw_req_vaddr), .i_ptw_req_store(i_ptw_req_store),
        .o_ptw_cache_rden(o_ptw_cache_rden), .o_ptw_cache_vaddr(o_ptw_cache_vaddr),
        .i_ptw_cache_hit(i_ptw_cache_hit), .i_ptw_cache_rdata(i_ptw_cache_rdata),
        .o_ptw_cache_wren(o_ptw_cache_wren), .o_ptw_cache_level(o_ptw_cache_level),
        .o_ptw_cache_pte(o_ptw_cache_pte), .o_ptw_mem_req_vld(o_ptw_mem_req_vld),
        .i_ptw_mem_req_rdy(i_ptw_mem_req_rdy), .o_ptw_mem_addr(o_ptw_mem_addr),
        .i_ptw_mem_resp_vld(i_ptw_mem_resp_vld), .i_ptw_mem_resp_data(i_ptw_mem_resp_data),
        .i_ptw_mem_resp_err(i_ptw_mem_resp_err), .o_ptw_resp_vld(o_ptw_resp_vld),
        .i_ptw_resp_rdy(i_ptw_resp_rdy), .o_ptw_resp_pte(o_ptw_resp_pte),
        .o_ptw_resp_level(o_ptw_resp_level), .o_ptw_resp_pf(o_ptw_resp_pf),
        .o_ptw_resp_af(o_ptw_resp_af)
    );

    typedef struct packed {
        logic [31:0] pte;
        logic [1:0]  level;
        logic        pf;
        logic        af;
    } exp_t;

    exp_t        exp_q[$];
    logic [33:0] refill_q[$];
    logic [33:0] addr_q[$];
    logic [31:0] mem [logic [33:0]];
    bit          merr [logic [33:0]];

    int errors = 0;
    int checks = 0;
    int resp_count = 0;

    logic [21:0] satp_ppn = '0;
    logic [31:0] exp_cvaddr = '0;
    logic        cur_hit = 1'b0;
    logic [33:0] cur_rdata = '0;
    int          mem_block = 0;
    int          resp_block = 0;
    logic [33:0] hold_addr = '1;
    bit          release_hold = 1'b0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [33:0] pend_a = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Reference walk: derives every address, the result and any refill straight from the Sv32 rules.
    task automatic predict(input logic [31:0] va, input logic st, input logic hit, input logic [33:0] rd);
        exp_t        e;
        logic [33:0] a;
        logic [31:0] p;
        e = '0;
        if (hit) begin
            e.pte   = rd[31:0];
            e.level = rd[33:32];
            e.pf    = !rd[6] || (st && !rd[7]);
            exp_q.push_back(e);
            return;
        end
        a = {satp_ppn, va[31:22], 2'b00};
        for (int lvl = 1; lvl >= 0; lvl--) begin
            addr_q.push_back(a);
            if (merr.exists(a)) begin
                e.af = 1'b1;
                break;
            end
            p = mem.exists(a) ? mem[a] : 32'd0;
            e.pte   = p;
            e.level = 2'(lvl);
            if (!p[0] || (!p[1] && p[2])) begin
                e.pf = 1'b1;
                break;
            end
            if (p[1] || p[3]) begin
                if (lvl == 1 && p[19:10] != 10'd0)   e.pf = 1'b1;
                else if (!p[6] || (st && !p[7]))    e.pf = 1'b1;
                else                                 refill_q.push_back({e.level, p});
                break;
            end
            if (lvl == 0) begin
                e.pf = 1'b1;
                break;
            end
            a = {p[31:10], va[21:12], 2'b00};
        end
        exp_q.push_back(e);
    endtask

    // PTE cache: answers the lookup combinationally in the same cycle as rden.
    initial forever begin
        @(negedge clk);
        if (rst_n && o_ptw_cache_rden) begin
            check("cache_vaddr", 64'(o_ptw_cache_vaddr), 64'(exp_cvaddr));
            i_ptw_cache_hit   = cur_hit;
            i_ptw_cache_rdata = cur_rdata;
        end else begin
            i_ptw_cache_hit   = 1'b0;
            i_ptw_cache_rdata = {2'($urandom), $urandom};
        end
    end

    // Memory: random request backpressure, one response per accepted request after a random delay.
    initial begin
        bit          prev_wait;
        logic [33:0] prev_addr;
        prev_wait = 1'b0;
        prev_addr = '0;
        forever begin
            @(negedge clk);
            i_ptw_mem_resp_vld  = 1'b0;
            i_ptw_mem_resp_err  = 1'b0;
            i_ptw_mem_resp_data = $urandom;
            if (pend) begin
                if (pend_cnt > 0) begin
                    pend_cnt--;
                end else if (pend_a != hold_addr || release_hold) begin
                    i_ptw_mem_resp_vld  = 1'b1;
                    i_ptw_mem_resp_data = mem.exists(pend_a) ? mem[pend_a] : 32'd0;
                    i_ptw_mem_resp_err  = merr.exists(pend_a);
                    pend = 1'b0;
                end
            end
            if (prev_wait) begin
                check("mem_req_held", 64'(o_ptw_mem_req_vld), 64'd1);
                check("mem_addr_stable", 64'(o_ptw_mem_addr), 64'(prev_addr));
            end
            if (o_ptw_mem_req_vld && mem_block > 0) begin
                mem_block--;
                i_ptw_mem_req_rdy = 1'b0;
            end else begin
                i_ptw_mem_req_rdy = ($urandom % 4) != 0;
            end
            prev_wait = rst_n && o_ptw_mem_req_vld && !i_ptw_mem_req_rdy;
            prev_addr = o_ptw_mem_addr;
            if (rst_n && o_ptw_mem_req_vld && i_ptw_mem_req_rdy) begin
                if (pend) fail_now("mem_req_while_outstanding");
                if (addr_q.size() == 0) fail_now("unexpected_mem_req");
                else check("mem_addr", 64'(o_ptw_mem_addr), 64'(addr_q.pop_front()));
                pend     = 1'b1;
                pend_a   = o_ptw_mem_addr;
                pend_cnt = $urandom_range(0, 3);
            end
        end
    end

    // Monitor: pops the scoreboard on every result handshake and every refill strobe.
    initial begin
        bit   prev_wait;
        exp_t prev_resp, cur, e;
        prev_wait = 1'b0;
        prev_resp = '0;
        forever begin
            @(negedge clk);
            cur = {o_ptw_resp_pte, o_ptw_resp_level, o_ptw_resp_pf, o_ptw_resp_af};
            if (prev_wait) begin
                check("resp_held", 64'(o_ptw_resp_vld), 64'd1);
                check("resp_stable", 64'(cur), 64'(prev_resp));
            end
            if (o_ptw_resp_vld && resp_block > 0) begin
                resp_block--;
                i_ptw_resp_rdy = 1'b0;
            end else begin
                i_ptw_resp_rdy = ($urandom % 3) != 0;
            end
            prev_wait = rst_n && o_ptw_resp_vld && !i_ptw_resp_rdy;
            prev_resp = cur;
            if (rst_n && o_ptw_resp_vld && i_ptw_resp_rdy) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_resp");
                end else begin
                    e = exp_q.pop_front();
                    check("resp_pf", 64'(o_ptw_resp_pf), 64'(e.pf));
                    check("resp_af", 64'(o_ptw_resp_af), 64'(e.af));
                    if (!e.pf && !e.af) begin
                        check("resp_pte", 64'(o_ptw_resp_pte), 64'(e.pte));
                        check("resp_level", 64'(o_ptw_resp_level), 64'(e.level));
                    end
                end
                resp_count++;
            end
            if (rst_n && o_ptw_cache_wren) begin
                if (refill_q.size() == 0) fail_now("unexpected_refill");
                else check("refill", 64'({o_ptw_cache_level, o_ptw_cache_pte}), 64'(refill_q.pop_front()));
            end
        end
    end

    task automatic do_walk(input logic [31:0] va, input logic st, input logic hit, input logic [33:0] rd);
        int t;
        int start;
        predict(va, st, hit, rd);
        i_csr_satp = {10'd0, satp_ppn};
        exp_cvaddr = va;
        cur_hit    = hit;
        cur_rdata  = rd;
        start      = resp_count;
        @(negedge clk);
        i_ptw_req_vld   = 1'b1;
        i_ptw_req_vaddr = va;
        i_ptw_req_store = st;
        t = 0;
        while (!o_ptw_req_rdy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) fail_now("req_rdy_timeout");
        @(negedge clk);
        i_ptw_req_vld   = 1'b0;
        i_ptw_req_vaddr = $urandom;
        if (hit) check("hit_lookup_cycle1", 64'(o_ptw_cache_rden), 64'd1);
        @(negedge clk);
        if (hit) check("hit_resp_cycle2", 64'(o_ptw_resp_vld), 64'd1);
        t = 0;
        while (resp_count == start && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) fail_now("resp_timeout");
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] gen_pte(input int kind, input bit lvl1);
        logic [31:0] r;
        r = $urandom;
        case (kind)
            0: r = r & ~32'h1;
            1: r = (r & ~32'hF) | 32'h5;
            2: r = (r & ~32'hFF) | 32'hCF;
            3: r = (r & ~32'h3F) | 32'h3;
            default: r = (r & ~32'h3FF) | 32'h1;
        endcase
        if (lvl1 && (kind == 2 || kind == 3) && ($urandom % 2) == 0) r[19:10] = '0;
        return r;
    endfunction

    task automatic setup_walk(input logic [31:0] l1, input logic [31:0] l0);
        mem.delete();
        merr.delete();
        satp_ppn = 22'h100;
        mem[34'h000100400] = l1;
        mem[34'h020000804] = l0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] va, p1;
        logic [33:0] a1, a0;
        int          t;
        repeat (3) @(negedge clk);
        check("reset_resp_vld", 64'(o_ptw_resp_vld), 64'd0);
        check("reset_mem_req_vld", 64'(o_ptw_mem_req_vld), 64'd0);
        check("reset_wren", 64'(o_ptw_cache_wren), 64'd0);
        check("reset_rden", 64'(o_ptw_cache_rden), 64'd0);
        check("reset_resp_pte", 64'(o_ptw_resp_pte), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        i_ptw_flush = 1'b1;
        #1 check("flush_idle_rdy_low", 64'(o_ptw_req_rdy), 64'd0);
        @(negedge clk);
        i_ptw_flush = 1'b0;
        #1 check("idle_rdy_high", 64'(o_ptw_req_rdy), 64'd1);

        satp_ppn = 22'h100;
        do_walk(32'h40201000, 1'b0, 1'b1, {2'd0, 32'h123450CF});
        setup_walk(32'h08000001, 32'h123450CF);
        do_walk(32'h40201000, 1'b0, 1'b0, '0);
        setup_walk(32'h200000CF, 32'h0);
        do_walk(32'h40201000, 1'b0, 1'b0, '0);
        setup_walk(32'h200004CF, 32'h0);
        do_walk(32'h40201000, 1'b0, 1'b0, '0);
        setup_walk(32'h00000000, 32'h0);
        do_walk(32'h40201000, 1'b0, 1'b0, '0);
        setup_walk(32'h08000001, 32'h0);
        merr[34'h000100400] = 1'b1;
        do_walk(32'h40201000, 1'b0, 1'b0, '0);
        setup_walk(32'h08000001, 32'h1234504F);
        do_walk(32'h40201000, 1'b1, 1'b0, '0);

        setup_walk(32'h08000001, 32'h123450CF);
        mem_block  = 5;
        resp_block = 3;
        do_walk(32'h40201000, 1'b0, 1'b0, '0);

        // Flush while the level-0 read is outstanding; its late response must be swallowed.
        setup_walk(32'h08000001, 32'h123450CF);
        i_csr_satp = {10'd0, satp_ppn};
        exp_cvaddr = 32'h40201000;
        cur_hit    = 1'b0;
        addr_q.push_back(34'h000100400);
        addr_q.push_back(34'h020000804);
        hold_addr = 34'h020000804;
        @(negedge clk);
        i_ptw_req_vld   = 1'b1;
        i_ptw_req_vaddr = 32'h40201000;
        i_ptw_req_store = 1'b0;
        @(negedge clk);
        i_ptw_req_vld = 1'b0;
        t = 0;
        while (!(pend && pend_a == hold_addr) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail_now("flush_setup_timeout");
        @(negedge clk);
        i_ptw_flush = 1'b1;
        @(negedge clk);
        i_ptw_flush = 1'b0;
        #1 check("drain_rdy_low", 64'(o_ptw_req_rdy), 64'd0);
        repeat (3) @(negedge clk);
        check("drain_still_waiting", 64'(o_ptw_req_rdy), 64'd0);
        release_hold = 1'b1;
        t = 0;
        while (pend && t < 50) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        #1 check("rdy_after_drain", 64'(o_ptw_req_rdy), 64'd1);
        check("flush_addrs_consumed", 64'(addr_q.size()), 64'd0);
        release_hold = 1'b0;
        hold_addr    = '1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < 150; i++) begin
            mem.delete();
            merr.delete();
            satp_ppn = 22'($urandom);
            va = $urandom;
            a1 = {satp_ppn, va[31:22], 2'b00};
            p1 = gen_pte(int'($urandom % 6), 1'b1);
            mem[a1] = p1;
            if (($urandom % 10) == 0) merr[a1] = 1'b1;
            a0 = {p1[31:10], va[21:12], 2'b00};
            if (a0 != a1) begin
                mem[a0] = gen_pte(int'($urandom % 6), 1'b0);
                if (($urandom % 10) == 0) merr[a0] = 1'b1;
            end
            do_walk(va, 1'($urandom), ($urandom % 4) == 0,
                    {2'($urandom % 2), gen_pte(int'(2 + $urandom % 2), 1'b0)});
        end

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("refill_q_drained", 64'(refill_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
